capp_array: RTL and testbench

- Content-addressable parallel processor core: a WORDS x WIDTH associative memory with one tag flip-flop per word.
- Three sub-functions:
  - compare: masked comparand broadcast.
  - cells: per-word match and wired-OR read.
  - tags: set, search-clear and select-first.
- Sits under the CAPP controller, which drives comparand/mask/commands and reads tags and read data.

---
 rtl/capp_array.sv | 129 ++++++++++++
 tb/tb_capp_array.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/capp_array.sv
// capp_array: associative memory of WORDS x WIDTH cells with one tag flip-flop
// per word. The array provides a masked comparand broadcast, a per-word match
// with a wired-OR read of all tagged words, and tag set / search-clear /
// select-first operations.
//
// Command strobes (set, perform_search, select_first, write) are single-cycle
// level requests with no handshake: every command sampled high at a rising
// edge of CLK completes at that edge. When several are high together only the
// highest-priority one executes, in the order
// set > perform_search > select_first > write.
// RST overrides every command.
module capp_array #(
  parameter int WORDS = 100,
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] comparand,
  input  logic [WIDTH-1:0] mask,
  input  logic             perform_search,
  input  logic             set,
  input  logic             select_first,
  input  logic             write,
  output logic [WORDS-1:0] tags,
  output logic [WORDS-1:0] match_lines,
  output logic [WIDTH-1:0] read_lines,
  output logic             some_tag
);

  // Decoded command after priority resolution.
  typedef enum logic [2:0] {
    CMD_NONE   = 3'd0,
    CMD_SET    = 3'd1,
    CMD_SEARCH = 3'd2,
    CMD_SELECT = 3'd3,
    CMD_WRITE  = 3'd4
  } cmd_e;

  localparam logic [WORDS-1:0] TAG_ONE = WORDS'(1);

  // Storage array and tag register.
  logic [WIDTH-1:0] mem [WORDS];
  logic [WORDS-1:0] tag_q;

  // Search line pair per column.
  logic [WIDTH-1:0] m1;  // a stored 1 in this column mismatches
  logic [WIDTH-1:0] m0;  // a stored 0 in this column mismatches

  cmd_e             cmd;
  logic [WORDS-1:0] tag_next;
  logic [WORDS-1:0] first_tag;
  logic [WIDTH-1:0] read_or;
  logic [WIDTH-1:0] write_bits;

  // Comparand broadcast: masked-off columns drive neither search line, so
  // they can never cause a mismatch.
  always_comb begin
    m1 = mask & ~comparand;
    m0 = mask & comparand;
  end

  // Per-word match: a word matches when no column flags a mismatch.
  for (genvar i = 0; i < WORDS; i++) begin : g_cell
    logic [WIDTH-1:0] mism;
    assign mism           = (mem[i] & m1) | (~mem[i] & m0);
    assign match_lines[i] = ~|mism;
  end

  // Priority resolution of simultaneous command strobes.
  always_comb begin
    cmd = CMD_NONE;
    if (set)                 cmd = CMD_SET;
    else if (perform_search) cmd = CMD_SEARCH;
    else if (select_first)   cmd = CMD_SELECT;
    else if (write)          cmd = CMD_WRITE;
  end

  // Lowest-index set tag isolated as a one-hot vector (bit 0 is word 0);
  // an all-zero tag register yields all zeros.
  always_comb begin
    first_tag = tag_q & (~tag_q + TAG_ONE);
  end

  // Next tag value for the decoded command.
  always_comb begin
    tag_next = tag_q;
    case (cmd)
      CMD_SET:    tag_next = '1;
      CMD_SEARCH: tag_next = tag_q & match_lines;
      CMD_SELECT: tag_next = first_tag;
      default:    tag_next = tag_q;
    endcase
  end

  // Tag register update.
  always_ff @(posedge CLK) begin
    if (RST) tag_q <= '0;
    else     tag_q <= tag_next;
  end

  // Data merged into a tagged word on write: masked columns take the comparand.
  always_comb begin
    write_bits = comparand & mask;
  end

  // Word storage: masked write of the comparand into every tagged word.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < WORDS; i++) begin
      if (RST) begin
        mem[i] <= '0;
      end else if (cmd == CMD_WRITE && tag_q[i]) begin
        mem[i] <= (mem[i] & ~mask) | write_bits;
      end
    end
  end

  // Wired-OR read of all tagged words; zero when no tag is set.
  always_comb begin
    read_or = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (tag_q[i]) read_or = read_or | mem[i];
    end
  end

  assign read_lines = read_or;
  assign tags       = tag_q;
  assign some_tag   = |tag_q;

endmodule

// File: tb/tb_capp_array.sv
// Self-checking bench for capp_array: directed scenarios followed by random
// command mixes, all compared against a word-level reference model.
module tb_capp_array;

  localparam int WORDS = 100;
  localparam int WIDTH = 32;

  // Clock / reset and DUT signals
  logic             CLK;
  logic             RST;
  logic [WIDTH-1:0] comparand;
  logic [WIDTH-1:0] mask;
  logic             perform_search;
  logic             set;
  logic             select_first;
  logic             write;
  logic [WORDS-1:0] tags;
  logic [WORDS-1:0] match_lines;
  logic [WIDTH-1:0] read_lines;
  logic             some_tag;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [WIDTH-1:0] ref_words [WORDS];
  logic [WORDS-1:0] ref_tags;

  // Scoreboard of expected read_lines values for directed steps
  logic [WIDTH-1:0] exp_q[$];

  capp_array #(.WORDS(WORDS), .WIDTH(WIDTH)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .comparand      (comparand),
    .mask           (mask),
    .perform_search (perform_search),
    .set            (set),
    .select_first   (select_first),
    .write          (write),
    .tags           (tags),
    .match_lines    (match_lines),
    .read_lines     (read_lines),
    .some_tag       (some_tag)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // A word matches when it agrees with the comparand on every masked column.
  function automatic logic [WORDS-1:0] ref_match(input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] m);
    logic [WORDS-1:0] r;
    for (int i = 0; i < WORDS; i++) r[i] = (((ref_words[i] ^ c) & m) == '0);
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] ref_read();
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WORDS; i++) if (ref_tags[i]) r = r | ref_words[i];
    return r;
  endfunction

  task automatic ref_step(input logic r, input logic s, input logic ps, input logic sf,
                          input logic w, input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] m);
    logic [WORDS-1:0] mt;
    logic [WORDS-1:0] nt;
    bit found;
    mt = ref_match(c, m);
    if (r) begin
      ref_tags = '0;
      for (int i = 0; i < WORDS; i++) ref_words[i] = '0;
    end else if (s) begin
      ref_tags = '1;
    end else if (ps) begin
      ref_tags = ref_tags & mt;
    end else if (sf) begin
      nt = '0;
      found = 0;
      for (int i = 0; i < WORDS; i++) begin
        if (!found && ref_tags[i]) begin
          nt[i] = 1'b1;
          found = 1;
        end
      end
      ref_tags = nt;
    end else if (w) begin
      for (int i = 0; i < WORDS; i++)
        if (ref_tags[i]) ref_words[i] = (ref_words[i] & ~m) | (c & m);
    end
  endtask

  // Driver: apply one cycle of inputs, check the combinational match before
  // the edge and the registered outputs after it.
  task automatic cycle(input logic r, input logic s, input logic ps, input logic sf,
                       input logic w, input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] m);
    RST = r; set = s; perform_search = ps; select_first = sf; write = w;
    comparand = c; mask = m;
    #1;
    check("match_lines", 128'(match_lines), 128'(ref_match(c, m)));
    @(posedge CLK);
    ref_step(r, s, ps, sf, w, c, m);
    #1;
    check("tags", 128'(tags), 128'(ref_tags));
    check("some_tag", 128'(some_tag), 128'(|ref_tags));
    check("read_lines", 128'(read_lines), 128'(ref_read()));
  endtask

  task automatic check_read_exp(input string tag);
    logic [WIDTH-1:0] e;
    e = exp_q.pop_front();
    check(tag, 128'(read_lines), 128'(e));
  endtask

  initial begin
    logic [WORDS-1:0] tag_pat;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] m;
    logic r, s, ps, sf, w;

    RST = 1'b1; set = 1'b0; perform_search = 1'b0; select_first = 1'b0; write = 1'b0;
    comparand = '0; mask = '0;
    ref_tags = '0;
    for (int i = 0; i < WORDS; i++) ref_words[i] = '0;
    @(posedge CLK); #1;

    // Reset, then idle with and without a mask
    cycle(1, 0, 0, 0, 0, 32'd0, 32'd0);
    cycle(0, 0, 0, 0, 0, 32'd457, 32'h0);
    tag_pat = '1;
    check("idle_match_mask0", 128'(match_lines), 128'(tag_pat));
    cycle(0, 0, 0, 0, 0, 32'd457, 32'h1FF);

    // set, write 457 everywhere
    cycle(0, 1, 0, 0, 0, 32'd0, 32'd0);
    cycle(0, 0, 0, 0, 1, 32'd457, 32'h1FF);
    exp_q.push_back(32'd457);
    check_read_exp("read_after_write457");
    check("tags_all_ones", 128'(tags), 128'(tag_pat));

    // select_first, then full-width write of 5 into word 0
    cycle(0, 0, 0, 1, 0, 32'd0, 32'd0);
    cycle(0, 0, 0, 0, 1, 32'd5, 32'hFFFF_FFFF);
    exp_q.push_back(32'd5);
    check_read_exp("read_after_write5");
    tag_pat = WORDS'(1);
    check("tags_only_bit0", 128'(tags), 128'(tag_pat));

    // set, then hold a search for 457 three cycles
    cycle(0, 1, 0, 0, 0, 32'd0, 32'd0);
    tag_pat = '1;
    tag_pat[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle(0, 0, 1, 0, 0, 32'd457, 32'h1FF);
      check("search_hold_tags", 128'(tags), 128'(tag_pat));
      exp_q.push_back(32'd457);
      check_read_exp("search_hold_read");
    end

    // Searches that leave tags unchanged, then a clearing search
    cycle(0, 0, 1, 0, 0, 32'd0, 32'd0);
    check("search_mask0_tags", 128'(tags), 128'(tag_pat));
    cycle(0, 0, 1, 0, 0, 32'd1, 32'd1);
    check("search_bit0_tags", 128'(tags), 128'(tag_pat));
    cycle(0, 0, 1, 0, 0, 32'd0, 32'h1FF);
    cycle(0, 0, 0, 1, 0, 32'd0, 32'd0);
    check("cleared_tags", 128'(tags), 128'(0));
    check("cleared_some_tag", 128'(some_tag), 128'(0));
    exp_q.push_back(32'd0);
    check_read_exp("cleared_read");

    // set beats perform_search in the same cycle
    cycle(0, 1, 1, 0, 0, 32'd0, 32'h1FF);
    tag_pat = '1;
    check("set_wins_tags", 128'(tags), 128'(tag_pat));

    // RST beats set; words are cleared too
    cycle(1, 1, 0, 0, 0, 32'd0, 32'd0);
    check("rst_wins_tags", 128'(tags), 128'(0));
    cycle(0, 1, 0, 0, 0, 32'd0, 32'd0);
    exp_q.push_back(32'd0);
    check_read_exp("rst_cleared_words");

    // Random command mixes
    for (int k = 0; k < 400; k++) begin
      r  = ($urandom_range(0, 99) < 2);
      s  = ($urandom_range(0, 99) < 10);
      ps = ($urandom_range(0, 99) < 35);
      sf = ($urandom_range(0, 99) < 12);
      w  = ($urandom_range(0, 99) < 35);
      c  = $urandom_range(0, 1) ? 32'($urandom_range(0, 7)) : 32'($urandom);
      m  = $urandom_range(0, 2) != 0 ? 32'h7 : 32'($urandom);
      cycle(r, s, ps, sf, w, c, m);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
